// File: rtl/stride_counter.sv
// Arithmetic-sequence counter with configurable bounds, run-time stride and direction,
// wrap/saturate/one-shot boundary handling and a small start/stop control FSM.
module stride_counter #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] LO    = WIDTH'(1),
    parameter logic [WIDTH-1:0] HI    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] stride_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             busy_q;
    logic             tc_q;
    logic             done_q;
    logic             ovf_q;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] step_d;
    logic             out_of_range;
    logic [WIDTH-1:0] load_clamped;

    // Extra MSB carries the carry-out (up) or borrow (down) of the step.
    always_comb begin
        sum_ext  = {1'b0, count_q} + {1'b0, stride_q};
        diff_ext = {1'b0, count_q} - {1'b0, stride_q};
        if (dir_q) begin
            step_d       = diff_ext[WIDTH-1:0];
            out_of_range = diff_ext[WIDTH] || (diff_ext[WIDTH-1:0] < LO);
        end else begin
            step_d       = sum_ext[WIDTH-1:0];
            out_of_range = sum_ext[WIDTH] || (sum_ext[WIDTH-1:0] > HI);
        end
        if (load_val_i < LO) begin
            load_clamped = LO;
        end else if (load_val_i > HI) begin
            load_clamped = HI;
        end else begin
            load_clamped = load_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= LO;
            stride_q <= STEP;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (stop_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (load_i) begin
                count_q <= load_clamped;
                if (state_q != S_IDLE) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            end else if (start_i) begin
                count_q  <= dir_i ? HI : LO;
                stride_q <= (step_i == '0) ? STEP : step_i;
                dir_q    <= dir_i;
                mode_q   <= mode_i;
                ovf_q    <= 1'b0;
                state_q  <= S_RUN;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end else if (state_q == S_RUN && en_i) begin
                if (!out_of_range) begin
                    count_q <= step_d;
                end else begin
                    tc_q <= 1'b1;
                    case (mode_q)
                        MODE_SAT: begin
                            state_q <= S_HOLD;
                        end
                        MODE_ONCE: begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                        // Reserved mode 11 behaves as wrap.
                        default: begin
                            count_q <= dir_q ? HI : LO;
                            ovf_q   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign tc_o    = tc_q;
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;

endmodule
